// File: rtl/fifo_pkg.sv
// Shared types and constants for the fifo_mem read-side controller.
package fifo_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned RD_LAT_MAX = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        BURST = 2'd2
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// In-order skid buffer holding popped FIFO words until downstream accepts them.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = DATA_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic                         head_valid,
    output logic [W-1:0]                 head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for fifo_mem: credit-limited reads, latency tracking, drain/burst FSM.
// Optional FIFO_RD_CNT_EN adds a 16-bit count of words delivered downstream.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              thr_mode,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    input  logic              fifo_threshold,
    input  logic              fifo_underflow,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              err_underflow
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]       rd_count
`endif
);

    localparam int unsigned SKID_DEPTH = RD_LAT + 1;
    localparam int unsigned CW         = $clog2(SKID_DEPTH + 1);
    localparam int unsigned AW         = CW + 1;

    if (BURST_LEN < 1 || BURST_LEN > 255 || RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_param
        $error("fifo_rd_ctrl: BURST_LEN must be 1..255 and RD_LAT 1..%0d", RD_LAT_MAX);
    end

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [7:0]        burst_cnt;
    logic [7:0]        burst_cnt_nxt;
    logic [RD_LAT-1:0] vld_sr;
    logic              rd_q;
    logic              err_q;
    logic [CW-1:0]     occ;
    logic [AW-1:0]     inflight;
    logic [AW-1:0]     credit_need;
    logic              credit_ok;
    logic              pop;
    logic              push;

    assign pop  = m_valid & m_ready;
    assign push = vld_sr[RD_LAT-1];

    // A word leaving this cycle frees its slot for a read issued this cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight = inflight + AW'(vld_sr[i]);
        end
        credit_need = AW'(occ) - AW'(pop) + inflight + AW'(1);
        credit_ok   = (credit_need <= AW'(SKID_DEPTH));
    end

    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        fifo_rd       = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !thr_mode && !fifo_empty) begin
                    state_nxt = DRAIN;
                end else if (enable && thr_mode && fifo_threshold) begin
                    state_nxt     = BURST;
                    burst_cnt_nxt = 8'(BURST_LEN);
                end
            end
            DRAIN: begin
                fifo_rd = enable & ~fifo_empty & credit_ok & ~rst;
                if (fifo_empty || !enable || thr_mode) begin
                    state_nxt = IDLE;
                end
            end
            BURST: begin
                fifo_rd = enable & ~fifo_empty & credit_ok & ~rst & (burst_cnt != 8'd0);
                if (fifo_rd) begin
                    burst_cnt_nxt = burst_cnt - 8'd1;
                end
                if (!enable || fifo_empty || (fifo_rd && burst_cnt == 8'd1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            vld_sr    <= '0;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            vld_sr[0] <= fifo_rd;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            rd_q  <= fifo_rd;
            err_q <= err_q | (fifo_underflow & rd_q);
        end
    end

    fifo_rd_skid #(
        .DEPTH (SKID_DEPTH),
        .W     (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (fifo_data),
        .pop        (pop),
        .head_valid (m_valid),
        .head_data  (m_data),
        .count      (occ)
    );

    assign busy          = (state != IDLE) | (|vld_sr) | (occ != '0);
    assign err_underflow = err_q;

`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: queue-based FIFO environment plus a per-cycle reference model,
// directed scenarios with literal expectations, then a randomized soak.
module tb_fifo_rd_ctrl;

    localparam int DW      = 8;
    localparam int RDL     = 2;
    localparam int BL      = 4;
    localparam int SKID    = RDL + 1;
    localparam int THR_LVL = 3;
    localparam int M_IDLE  = 0;
    localparam int M_DRAIN = 1;
    localparam int M_BURST = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          thr_mode;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_threshold;
    logic          fifo_underflow;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic          err_underflow;
`ifdef FIFO_RD_CNT_EN
    logic [15:0]   rd_count;
`endif

    fifo_rd_ctrl #(
        .DATA_W    (DW),
        .RD_LAT    (RDL),
        .BURST_LEN (BL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .thr_mode       (thr_mode),
        .fifo_rd        (fifo_rd),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .fifo_threshold (fifo_threshold),
        .fifo_underflow (fifo_underflow),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .busy           (busy),
        .err_underflow  (err_underflow)
`ifdef FIFO_RD_CNT_EN
        ,
        .rd_count       (rd_count)
`endif
    );

    always #5 clk = ~clk;

    // FIFO environment: stored words and the read-latency data pipe.
    int            fq[$];
    logic [DW-1:0] dp [RDL];

    // Reference model: mode, remaining burst words, in-flight words with age, output queue.
    int m_mode;
    int m_rem;
    int pend_d[$];
    int pend_a[$];
    int outq[$];
    bit m_err;
    bit m_prev_rd;
    int m_cnt;

    int passed;
    int total;
    int cyc;
    bit checking;
    int rd_pulses;
    int first_rd;
    int first_mv;
    bit last_rd;
    int got[$];
    int got_cyc[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s @cycle %0d: actual %0h required %0h", nm, cyc, act, exp);
    endtask

    task automatic clear_log();
        rd_pulses = 0;
        first_rd  = -1;
        first_mv  = -1;
        got.delete();
        got_cyc.delete();
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_rem  = 0;
        pend_d.delete();
        pend_a.delete();
        outq.delete();
        m_err     = 1'b0;
        m_prev_rd = 1'b0;
        m_cnt     = 0;
    endtask

    task automatic tick();
        bit e_rd;
        bit e_mv;
        bit e_busy;
        bit d_rd;
        int e_md;
        int head;
        fifo_empty     = (fq.size() == 0);
        fifo_threshold = (fq.size() >= THR_LVL);
        @(negedge clk);
        e_mv   = (outq.size() > 0);
        e_md   = e_mv ? outq[0] : 0;
        e_busy = (m_mode != M_IDLE) || (pend_d.size() > 0) || e_mv;
        e_rd   = ((m_mode == M_DRAIN) || (m_mode == M_BURST && m_rem > 0)) && enable && !fifo_empty && !rst
                 && (outq.size() - int'(e_mv && m_ready) + pend_d.size() + 1 <= SKID);
        if (checking) begin
            chk("fifo_rd", int'(fifo_rd), int'(e_rd));
            chk("m_valid", int'(m_valid), int'(e_mv));
            if (e_mv) chk("m_data", int'(m_data), e_md);
            chk("busy", int'(busy), int'(e_busy));
            chk("err_underflow", int'(err_underflow), int'(m_err));
`ifdef FIFO_RD_CNT_EN
            chk("rd_count", int'(rd_count), m_cnt);
`endif
        end
        d_rd    = fifo_rd;
        last_rd = fifo_rd;
        if (fifo_rd) begin
            rd_pulses++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready) begin
            got.push_back(int'(m_data));
            got_cyc.push_back(cyc);
        end
        head = (fq.size() > 0) ? fq[0] : 0;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            if (e_mv && m_ready) begin
                void'(outq.pop_front());
                m_cnt = (m_cnt + 1) % 65536;
            end
            while (pend_a.size() > 0 && pend_a[0] == 1) begin
                outq.push_back(pend_d.pop_front());
                void'(pend_a.pop_front());
            end
            foreach (pend_a[i]) pend_a[i]--;
            if (e_rd) begin
                pend_d.push_back(head);
                pend_a.push_back(RDL);
            end
            m_err     = m_err || (fifo_underflow && m_prev_rd);
            m_prev_rd = e_rd;
            case (m_mode)
                M_IDLE: begin
                    if (enable && !thr_mode && !fifo_empty) m_mode = M_DRAIN;
                    else if (enable && thr_mode && fifo_threshold) begin
                        m_mode = M_BURST;
                        m_rem  = BL;
                    end
                end
                M_DRAIN: if (fifo_empty || !enable || thr_mode) m_mode = M_IDLE;
                default: begin
                    if (e_rd) m_rem--;
                    if (!enable || m_rem == 0 || fifo_empty) m_mode = M_IDLE;
                end
            endcase
        end
        for (int i = RDL - 1; i > 0; i--) dp[i] = dp[i-1];
        if (d_rd) dp[0] = (fq.size() > 0) ? 8'(fq.pop_front()) : 8'hEE;
        else      dp[0] = 8'($urandom);
        fifo_data = dp[RDL-1];
    endtask

    task automatic chk_got(input string nm, input int base, input int n);
        chk({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_word%0d", nm, i), (i < got.size()) ? got[i] : -1, base + i);
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        cyc    = 0;
        checking       = 1'b0;
        rst            = 1'b1;
        enable         = 1'b0;
        thr_mode       = 1'b0;
        m_ready        = 1'b0;
        fifo_underflow = 1'b0;
        for (int i = 0; i < RDL; i++) dp[i] = '0;
        fifo_data = '0;
        model_reset();
        clear_log();
        repeat (2) tick();

        // Reset state, hand-computed.
        chk("rst_fifo_rd", int'(fifo_rd), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err_underflow), 0);
        rst      = 1'b0;
        checking = 1'b1;

        // Continuous drain of 0x01..0x05.
        for (int i = 1; i <= 5; i++) fq.push_back(i);
        enable  = 1'b1;
        m_ready = 1'b1;
        clear_log();
        repeat (20) tick();
        chk("drain_rd_pulses", rd_pulses, 5);
        chk_got("drain", 1, 5);
        chk("drain_latency", first_mv - first_rd, RDL + 1);
        chk("drain_back_to_back", (got_cyc.size() == 5) ? got_cyc[4] - got_cyc[0] : -1, 4);
        chk("drain_busy_end", int'(busy), 0);

        // Backpressure: only SKID reads may be outstanding.
        for (int i = 0; i < 8; i++) fq.push_back(8'h10 + i);
        m_ready = 1'b0;
        clear_log();
        repeat (12) tick();
        chk("bp_rd_pulses", rd_pulses, SKID);
        chk("bp_m_valid", int'(m_valid), 1);
        chk("bp_m_data", int'(m_data), 8'h10);
        m_ready = 1'b1;
        repeat (30) tick();
        chk_got("bp", 8'h10, 8);
        chk("bp_rd_total", rd_pulses, 8);

        // Threshold-triggered burst of BL words, leaving two behind.
        thr_mode = 1'b1;
        for (int i = 0; i < 6; i++) fq.push_back(8'h20 + i);
        clear_log();
        repeat (25) tick();
        chk("burst_rd_pulses", rd_pulses, BL);
        chk_got("burst", 8'h20, BL);
        chk("burst_left", fq.size(), 2);
        repeat (10) tick();
        chk("burst_no_retrigger", rd_pulses, BL);

        // Short burst: threshold reached with fewer than BL words.
        fq.push_back(8'h26);
        clear_log();
        repeat (25) tick();
        chk("short_rd_pulses", rd_pulses, 3);
        chk_got("short", 8'h24, 3);
        chk("short_err", int'(err_underflow), 0);
        chk("short_fifo_empty", fq.size(), 0);

        // Reset in the middle of a burst: in-flight words are discarded.
        for (int i = 0; i < 6; i++) fq.push_back(8'h30 + i);
        clear_log();
        repeat (4) tick();
        chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        enable = 1'b0;
        chk("post_rst_fifo_rd", int'(fifo_rd), 0);
        chk("post_rst_m_valid", int'(m_valid), 0);
        chk("post_rst_busy", int'(busy), 0);
        clear_log();
        repeat (10) tick();
        chk("post_rst_no_words", got.size(), 0);
        chk("post_rst_no_reads", rd_pulses, 0);
        enable   = 1'b1;
        thr_mode = 1'b0;
        repeat (20) tick();
        chk_got("post_rst", 8'h33, 3);

        // Underflow without a preceding read is ignored; after a read it sticks.
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        tick();
        chk("uf_no_read", int'(err_underflow), 0);
        fq.push_back(8'h40);
        fq.push_back(8'h41);
        last_rd = 1'b0;
        for (int i = 0; i < 10 && !last_rd; i++) tick();
        chk("uf_read_seen", int'(last_rd), 1);
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        tick();
        chk("uf_set", int'(err_underflow), 1);
        repeat (10) tick();
        chk("uf_sticky", int'(err_underflow), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("uf_cleared", int'(err_underflow), 0);

        // Randomized soak against the model.
        for (int n = 0; n < 3000; n++) begin
            enable  = ($urandom_range(7) != 0);
            m_ready = ($urandom_range(3) != 0);
            if ($urandom_range(49) == 0) thr_mode = ~thr_mode;
            if ($urandom_range(2) == 0 && fq.size() < 16) fq.push_back(int'($urandom_range(255)));
            rst            = ($urandom_range(299) == 0);
            fifo_underflow = ($urandom_range(39) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller for the fifo_mem buffer. Drives the FIFO's rd strobe from its data_out/fifo_empty/fifo_threshold/fifo_underflow status, and presents popped bytes downstream as a valid/ready stream.
- Contains a small skid buffer, so it sustains one read per clock under continuous downstream ready.
- Supports two modes: continuous drain, or threshold-triggered fixed-length bursts.

Parameters:
- DATA_W, 8, FIFO word width.
- RD_LAT, 1, cycles from fifo_rd sampled high to fifo_data valid (1..2).
- BURST_LEN, 8, words popped per threshold-triggered burst (1..255).
- SKID_DEPTH, RD_LAT+1, output buffer entries (localparam, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  permits issuing new FIFO reads.
- thr_mode  in  1  0 = continuous drain; 1 = burst on fifo_threshold.
- fifo_rd  out  1  read strobe to FIFO.
- fifo_data  in  DATA_W  FIFO data_out.
- fifo_empty  in  1  FIFO empty flag.
- fifo_threshold  in  1  FIFO threshold flag.
- fifo_underflow  in  1  FIFO underflow flag.
- m_valid  out  1  output word valid.
- m_data  out  DATA_W  output word.
- m_ready  in  1  downstream accepts word.
- busy  out  1  state != IDLE, or reads in flight, or buffer non-empty.
- err_underflow  out  1  sticky; cleared only by rst.

Behaviour:
- Reset (rst sampled high at clk edge): fifo_rd=0, m_valid=0, m_data=0, busy=0, err_underflow=0; state=IDLE; skid buffer and in-flight count cleared.
  - Reset mid-burst drops in-flight words; the words popped from the FIFO are lost, by design.
- Credit rule: fifo_rd=1 only when state is DRAIN or BURST, enable=1, fifo_empty=0, and (buffer occupancy + in-flight reads + 1) <= SKID_DEPTH, where occupancy counts the word leaving this cycle (m_valid & m_ready) as freed.
- Read data: fifo_data is captured exactly RD_LAT cycles after each fifo_rd=1, tracked by an RD_LAT-deep valid shift register. It is written into the skid buffer tail.
- Output: the skid buffer is in-order. m_data/m_valid come from the head and stay stable while m_valid=1 and m_ready=0.
  - Capture and pop in the same cycle are legal.
  - Minimum latency from fifo_rd to m_valid = RD_LAT + 1 cycles (registered output).
- FSM (IDLE, DRAIN, BURST):
  - IDLE -> DRAIN when enable & !thr_mode & !fifo_empty.
  - IDLE -> BURST when enable & thr_mode & fifo_threshold. Loads burst_cnt = BURST_LEN.
  - DRAIN -> IDLE when fifo_empty, or !enable, or thr_mode.
  - BURST: burst_cnt decrements on each fifo_rd. Go to IDLE when burst_cnt reaches 0 after the last read, or when fifo_empty with burst_cnt > 0 (short burst, no error).
  - BURST -> IDLE when enable drops. The remaining count is discarded.
- thr_mode changes take effect only in IDLE, except that DRAIN exits on thr_mode=1.
- In-flight reads and buffered words always complete to the output after any exit to IDLE.
- err_underflow sets when fifo_underflow=1 in any cycle where fifo_rd was issued in the previous cycle.
- Simultaneous fifo_threshold re-assertion in the exit cycle of BURST: IDLE for one cycle, then a new burst.
- burst_cnt is 8 bits; BURST_LEN=0 is illegal (elaboration check).

Optional Feature:
- Macro FIFO_RD_CNT_EN.
- Defined: adds output rd_count [15:0]. It increments on each m_valid & m_ready, wraps at 0xFFFF -> 0, and resets to 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package fifo_pkg holds:
  - state enum rd_state_t {IDLE=2'd0, DRAIN=2'd1, BURST=2'd2};
  - DATA_W default constant;
  - max RD_LAT constant.
- One sub-module: fifo_rd_skid, a parameterised in-order skid buffer (push/pop/occupancy).
- FSM, credit logic and latency tracking live in the top.

Test Plan:
- Continuous drain: FIFO preloaded 0x01..0x05, thr_mode=0, enable=1, m_ready=1 -> five fifo_rd pulses back-to-back. m_data 0x01..0x05 on consecutive cycles, first at RD_LAT+1 cycles after the first rd. busy falls after the last word.
- Backpressure: preloaded 0x10..0x17, m_ready held 0 -> exactly SKID_DEPTH reads issued, then fifo_rd=0. m_data stays 0x10. Releasing m_ready delivers 0x10..0x17 in order with no loss or duplication.
- Burst: thr_mode=1, BURST_LEN=4, FIFO filled until fifo_threshold=1 -> exactly 4 reads, return to IDLE, 4 words out. A second burst starts only on a new threshold.
- Short burst: BURST_LEN=8, FIFO holds 3 -> 3 reads, IDLE on fifo_empty, err_underflow stays 0.
- Reset mid-burst: rst=1 for one clock during BURST -> next cycle m_valid=0, fifo_rd=0, busy=0. No stale word appears afterwards.
- Underflow injection: force fifo_underflow=1 the cycle after a read -> err_underflow=1, held until rst.
